neuron_scheduler: RTL and testbench
===================================

# neuron_scheduler

Time-multiplexed controller that shares one membrane-potential update datapath among `N_NEURONS` neurons. Per-neuron potential and FREE/REFRACTORY state live in a register array. A round-robin index services one neuron per enabled cycle. Incoming spike pulses are latched until their neuron is serviced. The block emits per-neuron fire pulses and a selectable potential readout for the visualizer.

## Interface
Parameters:
- `N_NEURONS`, 4: neuron count, 2..16; index width is `IDX_W = $clog2(N_NEURONS)`.
- `c_THRESHOLD`, 500: fire level, 10-bit, must exceed `c_BASE`.
- `c_BASE`, 100: reset and refractory-exit level, 10-bit.

Ports:
- `i_Clk`, in, 1: clock.
- `i_Reset`, in, 1: synchronous, active-high reset.
- `i_Enable`, in, 1: when high, the scheduler advances one neuron per cycle.
- `i_Spike`, in, `N_NEURONS`: per-neuron spike pulses, any width.
- `i_Sel`, in, `IDX_W`: readout neuron select.
- `o_PSP_Trace`, out, 10: registered potential of neuron `i_Sel`.
- `o_Fire`, out, `N_NEURONS`: one-cycle pulse per neuron on FREE→REFRACTORY.
- `o_Sweep_Done`, out, 1: one-cycle pulse when neuron `N_NEURONS-1` is serviced.
- `o_Index`, out, `IDX_W`: neuron serviced this cycle.

## Operation
- Reset (sync, high) sets:
  - all potentials to `c_BASE` and all states to FREE;
  - the pending-spike register to 0 and the index to 0;
  - `o_Fire`, `o_Sweep_Done` and `o_Index` to 0;
  - `o_PSP_Trace` to `c_BASE`.
- Pending register, every cycle: `pending <= (pending | i_Spike) & ~clear`.
  - `clear` is the one-hot of the index when a neuron is serviced.
  - The spike seen for service is `pending[idx] | i_Spike[idx]`, so a spike arriving on the service cycle is consumed, not lost.
- Service happens when `i_Enable` is high. Neuron `idx` gets one update, then `idx <= (idx == N_NEURONS-1) ? 0 : idx+1`.
- Enable low:
  - index, potentials and states hold;
  - spikes keep latching;
  - `o_Fire` and `o_Sweep_Done` are 0.
- Update rule, p = 10-bit potential, all intermediates computed in 11-bit signed:
  - FREE and p ≥ `c_THRESHOLD`: state becomes REFRACTORY, p unchanged, `o_Fire[idx]` pulses next cycle.
  - FREE with spike: p += max(10 − (p>>5), 1), saturating at 1023.
  - FREE without spike: p −= p>>4 (leak; p never goes negative, floors naturally at p < 16).
  - REFRACTORY and p > `c_BASE`: p −= max(p>>5, 1). Any spike is consumed and discarded.
  - REFRACTORY and p ≤ `c_BASE`: state becomes FREE, p unchanged.
- The threshold test runs before the spike add. A neuron crossing the threshold fires on its next service.
- `o_PSP_Trace` is registered from `potential[i_Sel]` (post-update array value). `i_Sel` ≥ `N_NEURONS` reads neuron 0.

## Timing
- Service latency: the update of neuron k, applied at the edge where `o_Index == k` and `i_Enable == 1`, is visible in the array next cycle.
- `o_PSP_Trace` lags the array by one cycle.
- `o_Fire[k]` and `o_Sweep_Done` are registered and assert in the cycle after the service edge, for exactly one cycle.
- Sweep period is `N_NEURONS` enabled cycles. Each neuron is updated exactly once per sweep.
- Reset mid-sweep: all state returns to reset values on that edge, pending spikes are dropped, and the first service after reset is neuron 0.
- Simultaneous spike on the service cycle plus an already-pending spike: counts as one spike; there is no accumulation.

## Structure
- Package `neuron_pkg`:
  - `typedef enum logic {FREE, REFRACTORY} neuron_state_t`;
  - `PSP_W = 10`, `PSP_MAX = 1023`;
  - spike gain constant `SPIKE_GAIN = 10` and shift constants 5/4/5.
- Sub-module `neuron_update` holds the purely combinational next-state function:
  - inputs: p, state, spike;
  - outputs: p_next, state_next, fire.
- The scheduler holds the array, pending register, index counter and output registers.

## Test plan
- Reset with `N_NEURONS`=4, then 4 enabled cycles with no spikes → each potential 100→94, `o_Sweep_Done` pulses once, `o_Index` sequence 0,1,2,3.
- Spike neuron 2 while `o_Index`=0, enabled → neuron 2 becomes 107 (100 + 10 − 3); other neurons leak to 94; pending[2] clears.
- Spike pulse on neuron 1 exactly in its service cycle → 107. A spike on neuron 1 held during enable-low for 10 cycles, then released → only one increment on resume.
- Force neuron 0 to 500 FREE via repeated spikes → next service: `o_Fire[0]` single pulse, potential stays 500. Following services give 485, 470, … down to ≤100, then return to FREE with no decrement on that service.
- Spike during REFRACTORY → discarded, decrement unchanged. Potential near 1023 with spike → saturates at 1023, no wrap.
- Assert `i_Reset` while `o_Index`=2 with pending spikes → all potentials 100, pending 0, `o_Index` 0, `o_Fire` 0 next cycle.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and constants for the time-multiplexed neuron scheduler.
package neuron_pkg;

  typedef enum logic {FREE = 1'b0, REFRACTORY = 1'b1} neuron_state_t;

  localparam int PSP_W       = 10;
  localparam int PSP_MAX     = 1023;
  localparam int SPIKE_GAIN  = 10;
  localparam int SPIKE_SHIFT = 5;
  localparam int LEAK_SHIFT  = 4;
  localparam int REFR_SHIFT  = 5;

  typedef logic [PSP_W-1:0]      psp_t;
  typedef logic signed [PSP_W:0] psp_s_t;

endpackage

// File: rtl/neuron_update.sv
// Combinational membrane-potential update for one neuron (threshold, spike, leak, refractory).
module neuron_update
  import neuron_pkg::*;
#(
  parameter int c_THRESHOLD = 500,
  parameter int c_BASE      = 100
) (
  input  psp_t          p,
  input  neuron_state_t state,
  input  logic          spike,
  output psp_t          p_next,
  output neuron_state_t state_next,
  output logic          fire
);

  localparam psp_s_t THRESH_S = psp_s_t'(c_THRESHOLD);
  localparam psp_s_t BASE_S   = psp_s_t'(c_BASE);
  localparam psp_s_t ONE_S    = psp_s_t'(1);
  localparam psp_s_t GAIN_S   = psp_s_t'(SPIKE_GAIN);

  // One guard bit beyond the 11-bit operands so the clamp sees true overflow.
  function automatic psp_t sat_add(input psp_s_t a, input psp_s_t b);
    logic signed [PSP_W+1:0] s;
    s = (PSP_W+2)'(a) + (PSP_W+2)'(b);
    if (s > (PSP_W+2)'(PSP_MAX))
      sat_add = psp_t'(PSP_MAX);
    else if (s < 0)
      sat_add = '0;
    else
      sat_add = s[PSP_W-1:0];
  endfunction

  function automatic psp_s_t at_least_one(input psp_s_t v);
    at_least_one = (v < ONE_S) ? ONE_S : v;
  endfunction

  psp_s_t p_s;
  psp_s_t delta;

  always_comb begin
    p_s        = $signed({1'b0, p});
    delta      = '0;
    p_next     = p;
    state_next = state;
    fire       = 1'b0;
    if (state == FREE) begin
      // Threshold is tested before any spike contribution is added.
      if (p_s >= THRESH_S) begin
        state_next = REFRACTORY;
        fire       = 1'b1;
      end else if (spike) begin
        delta  = at_least_one(GAIN_S - (p_s >>> SPIKE_SHIFT));
        p_next = sat_add(p_s, delta);
      end else begin
        delta  = p_s >>> LEAK_SHIFT;
        p_next = sat_add(p_s, -delta);
      end
    end else begin
      if (p_s > BASE_S) begin
        delta  = at_least_one(p_s >>> REFR_SHIFT);
        p_next = sat_add(p_s, -delta);
      end else begin
        state_next = FREE;
      end
    end
  end

endmodule

// File: rtl/neuron_scheduler.sv
// Round-robin scheduler sharing one neuron_update datapath across N_NEURONS neurons,
// with latched spikes, fire pulses and a registered potential readout.
module neuron_scheduler
  import neuron_pkg::*;
#(
  parameter int  N_NEURONS   = 4,
  parameter int  c_THRESHOLD = 500,
  parameter int  c_BASE      = 100,
  localparam int IDX_W       = $clog2(N_NEURONS)
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic                 i_Enable,
  input  logic [N_NEURONS-1:0] i_Spike,
  input  logic [IDX_W-1:0]     i_Sel,
  output logic [PSP_W-1:0]     o_PSP_Trace,
  output logic [N_NEURONS-1:0] o_Fire,
  output logic                 o_Sweep_Done,
  output logic [IDX_W-1:0]     o_Index
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  psp_t                 potential [N_NEURONS];
  neuron_state_t        state     [N_NEURONS];
  logic [N_NEURONS-1:0] pending;
  logic [N_NEURONS-1:0] clear;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     sel_idx;
  logic [31:0]          sel_ext;
  logic                 svc_spike;
  psp_t                 upd_p;
  neuron_state_t        upd_state;
  logic                 upd_fire;
  logic [N_NEURONS-1:0] fire_p1;
  logic                 sweep_p1;
  psp_t                 trace_p1;

  // A spike arriving on the service cycle is consumed directly, so it cannot be lost.
  assign svc_spike = pending[idx] | i_Spike[idx];
  assign clear     = i_Enable ? (N_NEURONS'(1) << idx) : '0;
  assign sel_ext   = 32'(i_Sel);
  assign sel_idx   = (sel_ext < N_NEURONS) ? i_Sel : '0;

  neuron_update #(
    .c_THRESHOLD(c_THRESHOLD),
    .c_BASE     (c_BASE)
  ) u_update (
    .p         (potential[idx]),
    .state     (state[idx]),
    .spike     (svc_spike),
    .p_next    (upd_p),
    .state_next(upd_state),
    .fire      (upd_fire)
  );

  // Stage p1: array writeback and registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        potential[i] <= psp_t'(c_BASE);
        state[i]     <= FREE;
      end
      pending  <= '0;
      idx      <= '0;
      fire_p1  <= '0;
      sweep_p1 <= 1'b0;
      trace_p1 <= psp_t'(c_BASE);
    end else begin
      pending  <= (pending | i_Spike) & ~clear;
      trace_p1 <= potential[sel_idx];
      fire_p1  <= '0;
      sweep_p1 <= 1'b0;
      if (i_Enable) begin
        potential[idx] <= upd_p;
        state[idx]     <= upd_state;
        fire_p1        <= upd_fire ? clear : '0;
        sweep_p1       <= (idx == LAST_IDX);
        idx            <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    end
  end

  assign o_PSP_Trace  = trace_p1;
  assign o_Fire       = fire_p1;
  assign o_Sweep_Done = sweep_p1;
  assign o_Index      = idx;

endmodule

// File: tb/tb_neuron_scheduler.sv
// Scoreboard bench for neuron_scheduler: directed stimulus pushes expectations, a negedge monitor checks them.
module tb_neuron_scheduler;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en;
  logic [N-1:0] spike, hold;
  logic [1:0]   sel;
  logic [9:0]   trace;
  logic [N-1:0] fire;
  logic         sweep_done;
  logic [1:0]   index;

  logic         rst2, en2, sel2;
  logic [1:0]   spike2;
  logic [9:0]   trace2;
  logic [1:0]   fire2;
  logic         sweep2, index2;

  neuron_scheduler #(.N_NEURONS(4), .c_THRESHOLD(500), .c_BASE(100)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en), .i_Spike(spike), .i_Sel(sel),
    .o_PSP_Trace(trace), .o_Fire(fire), .o_Sweep_Done(sweep_done), .o_Index(index)
  );

  neuron_scheduler #(.N_NEURONS(2), .c_THRESHOLD(1023), .c_BASE(100)) dut_sat (
    .i_Clk(clk), .i_Reset(rst2), .i_Enable(en2), .i_Spike(spike2), .i_Sel(sel2),
    .o_PSP_Trace(trace2), .o_Fire(fire2), .o_Sweep_Done(sweep2), .o_Index(index2)
  );

  typedef enum int {S_TRACE, S_INDEX, S_FIRE, S_SWEEP, S_TRACE2, S_FIRE2, S_INDEX2, S_SWEEP2} sig_t;
  typedef struct {
    int    cyc;
    sig_t  sig;
    int    exp;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   fire_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sample(input sig_t s);
    case (s)
      S_TRACE:  return int'(trace);
      S_INDEX:  return int'(index);
      S_FIRE:   return int'(fire);
      S_SWEEP:  return int'(sweep_done);
      S_TRACE2: return int'(trace2);
      S_FIRE2:  return int'(fire2);
      S_INDEX2: return int'(index2);
      default:  return int'(sweep2);
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle, away from the active edge.
  always @(negedge clk) begin
    if (fire != '0) fire_seen++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        if (sb[i].cyc < cyc || sample(sb[i].sig) != sb[i].exp) begin
          errors++;
          $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                   sb[i].name, sample(sb[i].sig), sb[i].exp, cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input sig_t s, input int v, input string nm);
    exp_t e;
    e.cyc  = cyc;
    e.sig  = s;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; spike = '0; hold = '0;
    step();
    push_exp(S_INDEX, 0, "reset index");
    push_exp(S_FIRE, 0, "reset fire");
    push_exp(S_SWEEP, 0, "reset sweep_done");
    push_exp(S_TRACE, 100, "reset trace");
    rst = 1'b0;
  endtask

  task automatic sweep(input logic [N-1:0] fire_exp, input int spk_step, input logic [N-1:0] spk_pulse);
    en = 1'b1;
    for (int k = 0; k < N; k++) begin
      spike = hold | ((k == spk_step) ? spk_pulse : '0);
      step();
      push_exp(S_FIRE, int'(fire_exp & (N'(1) << k)), $sformatf("fire after svc %0d", k));
      push_exp(S_SWEEP, (k == N - 1) ? 1 : 0, $sformatf("sweep_done after svc %0d", k));
      push_exp(S_INDEX, (k + 1) % N, $sformatf("index after svc %0d", k));
    end
    en = 1'b0;
    spike = hold;
  endtask

  task automatic peek(input int k, input int v);
    sel = 2'(k);
    step();
    push_exp(S_TRACE, v, $sformatf("psp[%0d]", k));
  endtask

  int rtab_r[9] = '{1, 2, 3, 10, 23, 40, 55, 56, 57};
  int rtab_v[9] = '{485, 470, 456, 368, 248, 151, 100, 100, 94};

  initial begin
    rst = 1'b0; en = 1'b0; spike = '0; hold = '0; sel = '0;
    rst2 = 1'b1; en2 = 1'b0; spike2 = '0; sel2 = 1'b0;

    // Plain leak sweep from reset.
    do_reset();
    sweep('0, -1, '0);
    for (int k = 0; k < N; k++) peek(k, 94);

    // Spike on neuron 2 latched while neuron 0 is serviced.
    do_reset();
    sweep('0, 0, 4'b0100);
    peek(0, 94); peek(1, 94); peek(2, 107); peek(3, 94);
    sweep('0, -1, '0);
    peek(2, 101); peek(0, 89);

    // Spike exactly on neuron 1's service cycle.
    do_reset();
    sweep('0, 1, 4'b0010);
    peek(1, 107); peek(0, 94);
    sweep('0, -1, '0);
    peek(1, 101);

    // Spike held through ten disabled cycles counts once.
    hold = 4'b0010; spike = hold;
    for (int c = 0; c < 10; c++) begin
      step();
      push_exp(S_FIRE, 0, "fire while disabled");
      push_exp(S_SWEEP, 0, "sweep_done while disabled");
      push_exp(S_INDEX, 0, "index while disabled");
    end
    hold = '0; spike = '0;
    sweep('0, -1, '0);
    peek(1, 108);
    sweep('0, -1, '0);
    peek(1, 102);

    // Drive neuron 0 up to threshold, then fire and refractory decay.
    do_reset();
    hold = 4'b0001;
    for (int s = 1; s <= 262; s++) begin
      sweep('0, -1, '0);
      if (s == 4)   peek(0, 128);
      if (s == 10)  peek(0, 164);
      if (s == 262) peek(0, 500);
    end
    hold = '0; spike = '0;
    sweep(4'b0001, -1, '0);
    peek(0, 500);
    for (int r = 1; r <= 57; r++) begin
      sweep('0, (r == 3) ? 0 : -1, 4'b0001);
      for (int t = 0; t < 9; t++)
        if (rtab_r[t] == r) peek(0, rtab_v[t]);
    end

    // Reset in mid-sweep with spikes pending.
    do_reset();
    en = 1'b1;
    step(); push_exp(S_INDEX, 1, "pre-reset index");
    step(); push_exp(S_INDEX, 2, "pre-reset index");
    en = 1'b0; spike = 4'b1111;
    step();
    spike = '0; rst = 1'b1;
    step();
    push_exp(S_INDEX, 0, "mid-sweep reset index");
    push_exp(S_FIRE, 0, "mid-sweep reset fire");
    push_exp(S_TRACE, 100, "mid-sweep reset trace");
    rst = 1'b0;
    step();
    push_exp(S_FIRE, 0, "fire after reset release");
    push_exp(S_INDEX, 0, "index after reset release");
    sweep('0, -1, '0);
    for (int k = 0; k < N; k++) peek(k, 94);

    // Saturation near 1023 on a high-threshold instance.
    step();
    push_exp(S_TRACE2, 100, "sat reset trace");
    push_exp(S_INDEX2, 0, "sat reset index");
    push_exp(S_SWEEP2, 0, "sat reset sweep_done");
    rst2 = 1'b0; spike2 = 2'b01; en2 = 1'b1;
    for (int c = 0; c < 784 * 2; c++) step();
    en2 = 1'b0;
    step(); push_exp(S_TRACE2, 1022, "sat psp before top");
    en2 = 1'b1;
    step(); push_exp(S_FIRE2, 0, "sat fire on top step");
    step();
    en2 = 1'b0;
    step(); push_exp(S_TRACE2, 1023, "sat psp clamped");
    en2 = 1'b1;
    step(); push_exp(S_FIRE2, 1, "sat fire at 1023");
    step(); push_exp(S_FIRE2, 0, "sat fire single pulse");
    en2 = 1'b0;
    step(); push_exp(S_TRACE2, 1023, "sat psp no wrap");

    step(); step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
    end
    checks++;
    if (fire_seen != 1) begin
      errors++;
      $display("FAIL total fire pulses: got %0d, expected 1", fire_seen);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
